// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the fetch/decode/execute pipeline and the fetch controller.
// The pipeline side drives decode/MDU status; the controller returns PC and stall controls.
interface fetch_ctrl_if;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic        d_br;
    logic        d_br_taken;
    logic [15:0] d_imm16;
    logic        d_j;
    logic [25:0] d_index;
    logic        d_jr;
    logic [31:0] d_rs;
    logic        d_hazard;
    logic        d_use_md;
    logic        mdu_start;
    logic        mdu_is_div;
    logic [31:0] next_pc;
    logic        fetch_en;
    logic        d_en;
    logic        e_flush;
    logic        mdu_busy;
    logic [31:0] stall_cnt;

    modport master (
        output pc_f, pc_d, d_br, d_br_taken, d_imm16, d_j, d_index, d_jr, d_rs,
               d_hazard, d_use_md, mdu_start, mdu_is_div,
        input  next_pc, fetch_en, d_en, e_flush, mdu_busy, stall_cnt
    );

    modport slave (
        input  pc_f, pc_d, d_br, d_br_taken, d_imm16, d_j, d_index, d_jr, d_rs,
               d_hazard, d_use_md, mdu_start, mdu_is_div,
        output next_pc, fetch_en, d_en, e_flush, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: next-PC selection with a single delay slot, pipeline stall
// generation, multiply/divide busy countdown and a saturating stall-cycle counter.
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    fetch_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } mdu_state_t;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    mdu_state_t  state_q;
    mdu_state_t  state_n;
    logic [3:0]  count_q;
    logic [3:0]  count_n;
    logic [31:0] stall_cnt_q;

    logic        mdu_busy;
    logic        stall;
    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] br_offset;

    // Redirect targets are computed every cycle; the delay slot (pc_f) is never squashed.
    always_comb begin
        seq_pc    = bus.pc_f + 32'd4;
        br_offset = {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
        br_target = bus.pc_d + 32'd4 + br_offset;
        j_target  = {bus.pc_d[31:28], bus.d_index, 2'b00};
    end

    always_comb begin
        bus.next_pc = seq_pc;
        if (bus.d_jr) begin
            bus.next_pc = bus.d_rs;
        end else if (bus.d_j) begin
            bus.next_pc = j_target;
        end else if (bus.d_br && bus.d_br_taken) begin
            bus.next_pc = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
        end
    end

    // A start request while already counting is deliberately dropped, not queued.
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        case (state_q)
            IDLE: begin
                if (bus.mdu_start) begin
                    count_n = bus.mdu_is_div ? DIV_CYCLES : MULT_CYCLES;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (count_q <= 4'd1) begin
                    count_n = 4'd0;
                    state_n = IDLE;
                end else begin
                    count_n = count_q - 4'd1;
                end
            end
            default: begin
                count_n = 4'd0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        mdu_busy     = (count_q != 4'd0);
        stall        = ~reset & (bus.d_hazard | (bus.d_use_md & (mdu_busy | bus.mdu_start)));
        bus.mdu_busy = mdu_busy;
        bus.fetch_en = ~stall;
        bus.d_en     = ~stall;
        bus.e_flush  = stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: pc_f  in  32  PC currently held by the fetch unit.
REQ-004 SHALL have ports: pc_d  in  32  PC of the instruction in Decode.
REQ-005 SHALL have ports: d_br  in  1  Decode holds a conditional branch; d_br_taken  in  1  its comparison result; d_imm16  in  16  branch offset.
REQ-006 SHALL have ports: d_j  in  1  Decode holds j/jal; d_index  in  26  jump index.
REQ-007 SHALL have ports: d_jr  in  1  Decode holds jr/jalr; d_rs  in  32  forwarded rs value.
REQ-008 SHALL have ports: d_hazard  in  1  data-hazard stall request from the hazard unit.
REQ-009 SHALL have ports: d_use_md  in  1  Decode instruction needs the multiply/divide unit.
REQ-010 SHALL have ports: mdu_start  in  1  Execute launches an MDU op this cycle; mdu_is_div  in  1  op is div/divu.
REQ-011 SHALL have ports: next_pc  out  32  PC for the fetch unit to load.
REQ-012 SHALL have ports: fetch_en  out  1  fetch PC update enable; d_en  out  1  F/D register enable; e_flush  out  1  insert bubble into D/E.
REQ-013 SHALL have ports: mdu_busy  out  1  MDU countdown active; stall_cnt  out  32  stall-cycle counter.

Function
REQ-014 Redirect target SHALL be, by priority: d_jr -> d_rs; else d_j -> {pc_d[31:28], d_index, 2'b00}; else d_br & d_br_taken -> pc_d + 4 + (sign_ext(d_imm16) << 2); all sums modulo 2^32.
REQ-015 With no redirect, next_pc SHALL be pc_f + 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-016 next_pc SHALL be combinational; delay slot (pc_f) always fetched, never squashed.
REQ-017 stall SHALL be d_hazard | (d_use_md & (mdu_busy | mdu_start)).
REQ-018 On stall: fetch_en=0, d_en=0, e_flush=1; redirect still computed but ignored by fetch since fetch_en=0.
REQ-019 With no stall: fetch_en=1, d_en=1, e_flush=0.
REQ-020 MDU counter states: IDLE (count==0), BUSY (count!=0); mdu_busy = (count != 0).
REQ-021 In IDLE, mdu_start SHALL load count with 5 (mult/multu) or 10 (mdu_is_div=1) at the edge; mdu_busy high for exactly that many following cycles.
REQ-022 In BUSY, count SHALL decrement by 1 per cycle; mdu_start while BUSY SHALL be ignored (no reload).
REQ-023 d_use_md=0 SHALL never stall on MDU state.
REQ-024 stall_cnt SHALL increment by 1 each cycle stall=1, saturating at 32'hFFFF_FFFF.

Reset
REQ-025 With reset=1 at an edge: count=0, stall_cnt=0.
REQ-026 While reset=1, stall SHALL be forced 0 (fetch_en=1, d_en=1, e_flush=0); mdu_start ignored.
REQ-027 Reset mid-BUSY SHALL abort the countdown; mdu_busy=0 the cycle after.

Verification
REQ-028 pc_f=0x00003000, no redirect -> next_pc=0x00003004, fetch_en=1, e_flush=0.
REQ-029 pc_d=0x00003008, d_br=1, d_br_taken=1, d_imm16=0xFFFE -> next_pc=0x00003004; d_br_taken=0 -> pc_f+4.
REQ-030 d_jr=1, d_j=1, d_rs=0x00004000 -> next_pc=0x00004000; d_j alone, pc_d=0x00003010, d_index=0x0000C10 -> 0x00003040.
REQ-031 mdu_start=1, mdu_is_div=1 at cycle 0, d_use_md=1 -> stall cycles 0..10, fetch_en=1 at cycle 11, stall_cnt=11.
REQ-032 mult started, mdu_start reasserted at cycle 2 -> busy still ends after cycle 5; reset at cycle 3 -> mdu_busy=0 cycle 4, stall_cnt=0.
REQ-033 stall_cnt preset 0xFFFFFFFE via 2^32-2 stalls (force) + 3 stall cycles -> holds 0xFFFFFFFF.
